// File: rtl/ram_s2_s16_fifo_ctrl.sv
// ram_s2_s16_fifo_ctrl
//   FIFO controller in front of a dual-width RAM. Port A is 2 bits wide and
//   takes one symbol per write. Port B is 16 bits wide and returns one packed
//   word per read. Symbol k (0..7) of word w is stored at A-address 8w+k, so it
//   appears on RD_DATA[2k+1:2k].
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   WR_VALID/WR_DATA/WR_READY    2-bit symbol push handshake
//   RD_VALID/RD_DATA/RD_READY    16-bit word pop handshake (RD_DATA = RAM_DOB)
//   RAM_ADDRA/DIA/ENA/WEA        RAM 2-bit write port
//   RAM_ADDRB/ENB/WEB/RSTB/DOB   RAM 16-bit read port (1-cycle registered read)
//   WORD_COUNT, PARTIAL          completed words held / symbols in the open word
//   FULL, EMPTY, ALMOST_FULL     registered status flags
//
// Read FSM
//   state   | meaning
//   IDLE    | no word fetched; issues a read when a completed word exists
//   FETCH   | read issued last cycle, RAM_DOB valid from the next edge
//   PRESENT | RD_VALID=1, RAM_DOB held (RAM_ENB=0) until popped
module ram_s2_s16_fifo_ctrl #(
   parameter int ALMOST_FULL_WORDS = 248
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WR_VALID,
   input  logic [1:0]  WR_DATA,
   output logic        WR_READY,
   output logic        RD_VALID,
   output logic [15:0] RD_DATA,
   input  logic        RD_READY,
   output logic [10:0] RAM_ADDRA,
   output logic [1:0]  RAM_DIA,
   output logic        RAM_ENA,
   output logic        RAM_WEA,
   output logic [7:0]  RAM_ADDRB,
   output logic        RAM_ENB,
   output logic        RAM_WEB,
   output logic        RAM_RSTB,
   input  logic [15:0] RAM_DOB,
   output logic [8:0]  WORD_COUNT,
   output logic [2:0]  PARTIAL,
   output logic        FULL,
   output logic        EMPTY,
   output logic        ALMOST_FULL
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   localparam logic [9:0] AF_WORDS = 10'(ALMOST_FULL_WORDS);

   state_t      state_q, state_d;
   logic [11:0] wp_q, wp_d;
   logic [8:0]  rp_q, rp_d;
   logic        full_q, full_d;
   logic        empty_q, empty_d;
   logic        af_q, af_d;

   logic        push;
   logic        pop;
   logic        enb;
   logic [8:0]  word_cnt;
   logic [8:0]  word_cnt_d;
   logic [11:0] occ_d;

   always_comb begin
      // Pushes and pops offered while RST is high are not handshaken, so the
      // RAM is never written during reset.
      push     = WR_VALID & ~full_q & ~RST;
      pop      = (state_q == ST_PRESENT) & RD_READY & ~RST;
      word_cnt = wp_q[11:3] - rp_q;

      wp_d    = wp_q + {11'd0, push};
      rp_d    = rp_q + {8'd0, pop};
      state_d = state_q;
      enb     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (word_cnt != 9'd0) begin
               state_d = ST_FETCH;
               enb     = 1'b1;
            end
         end
         ST_FETCH: begin
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (pop) begin
               // word_cnt still includes the word being popped
               if (word_cnt > 9'd1) begin
                  state_d = ST_FETCH;
                  enb     = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (RST) begin
         wp_d    = 12'd0;
         rp_d    = 9'd0;
         state_d = ST_IDLE;
         enb     = 1'b0;
      end

      // Flags are registered from next-state pointers so they line up with
      // the pointer registers.
      word_cnt_d = wp_d[11:3] - rp_d;
      occ_d      = wp_d - {rp_d, 3'b000};
      full_d     = (occ_d == 12'd2048);
      empty_d    = (word_cnt_d == 9'd0);
      af_d       = ({1'b0, word_cnt_d} >= AF_WORDS);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         wp_q    <= 12'd0;
         rp_q    <= 9'd0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
      end
   end

   assign WR_READY    = ~full_q & ~RST;
   assign RD_VALID    = (state_q == ST_PRESENT) & ~RST;
   assign RD_DATA     = RAM_DOB;
   assign RAM_ADDRA   = wp_q[10:0];
   assign RAM_DIA     = WR_DATA;
   assign RAM_ENA     = push;
   assign RAM_WEA     = push;
   // The read after a pop must target RP+1 in the same cycle, so port B is
   // addressed from the next-state read pointer (equals RP when not popping).
   assign RAM_ADDRB   = rp_d[7:0];
   assign RAM_ENB     = enb;
   assign RAM_WEB     = 1'b0;
   assign RAM_RSTB    = 1'b0;
   assign WORD_COUNT  = word_cnt;
   assign PARTIAL     = wp_q[2:0];
   assign FULL        = full_q;
   assign EMPTY       = empty_q;
   assign ALMOST_FULL = af_q;

endmodule

// File: tb/tb_ram_s2_s16_fifo_ctrl.sv
// Testbench for ram_s2_s16_fifo_ctrl with a behavioural dual-width RAM.
module tb_ram_s2_s16_fifo_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WR_VALID;
   logic [1:0]  WR_DATA;
   logic        WR_READY;
   logic        RD_VALID;
   logic [15:0] RD_DATA;
   logic        RD_READY;
   logic [10:0] RAM_ADDRA;
   logic [1:0]  RAM_DIA;
   logic        RAM_ENA;
   logic        RAM_WEA;
   logic [7:0]  RAM_ADDRB;
   logic        RAM_ENB;
   logic        RAM_WEB;
   logic        RAM_RSTB;
   logic [15:0] RAM_DOB;
   logic [8:0]  WORD_COUNT;
   logic [2:0]  PARTIAL;
   logic        FULL;
   logic        EMPTY;
   logic        ALMOST_FULL;

   int tests  = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   ram_s2_s16_fifo_ctrl #(.ALMOST_FULL_WORDS(248)) dut (
      .CLK(CLK), .RST(RST),
      .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
      .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_READY(RD_READY),
      .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
      .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_RSTB(RAM_RSTB),
      .RAM_DOB(RAM_DOB),
      .WORD_COUNT(WORD_COUNT), .PARTIAL(PARTIAL),
      .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL)
   );

   // RAM: 2048 x 2-bit write port, 256 x 16-bit registered read port
   logic [1:0] mem [0:2047];
   always @(posedge CLK) begin
      if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
      if (RAM_ENB) begin
         for (int k = 0; k < 8; k++) RAM_DOB[2*k +: 2] <= mem[{RAM_ADDRB, 3'(k)}];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; WR_VALID = 1'b0; WR_DATA = 2'd0; RD_READY = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   function automatic logic [1:0] sym(input int i);
      return 2'((i ^ (i >> 3)) & 3);
   endfunction

   typedef struct {
      logic        wv;
      logic [1:0]  wd;
      logic        rr;
      logic        e_rv;
      logic [15:0] e_data;
      logic [8:0]  e_wc;
      logic [2:0]  e_part;
      logic        e_empty;
      logic        e_enb;
   } vec_t;

   function automatic vec_t mk(logic wv, logic [1:0] wd, logic rr, logic rv,
                               logic [15:0] d, logic [8:0] wc, logic [2:0] p,
                               logic em, logic enb);
      vec_t v;
      v.wv = wv; v.wd = wd; v.rr = rr; v.e_rv = rv; v.e_data = d;
      v.e_wc = wc; v.e_part = p; v.e_empty = em; v.e_enb = enb;
      return v;
   endfunction

   vec_t vt [26];

   logic [1:0]  pat [8] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2};
   logic [1:0]  symq [$];
   logic [15:0] w0, w1, expw, prev_data;
   logic        prev_hold, seen_enb, seen_rv;
   logic [7:0]  addrb_seen;
   int          pushed, popped, cycles;

   initial begin
      // Table: packing 0,1,2,3,0,1,2,3 -> E4E4 with immediate pop, then a
      // word of all 3s held under backpressure before popping.
      for (int i = 0; i < 8; i++)
         vt[i] = mk(1'b1, 2'(i % 4), 1'b1, 1'b0, 16'h0, 9'd0, 3'(i), 1'b1, 1'b0);
      vt[8]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 16'h0,    9'd1, 3'd0, 1'b0, 1'b1);
      vt[9]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 16'h0,    9'd1, 3'd0, 1'b0, 1'b0);
      vt[10] = mk(1'b0, 2'd0, 1'b1, 1'b1, 16'hE4E4, 9'd1, 3'd0, 1'b0, 1'b0);
      vt[11] = mk(1'b0, 2'd0, 1'b1, 1'b0, 16'h0,    9'd0, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         vt[12+i] = mk(1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 9'd0, 3'(i), 1'b1, 1'b0);
      vt[20] = mk(1'b0, 2'd0, 1'b0, 1'b0, 16'h0,    9'd1, 3'd0, 1'b0, 1'b1);
      vt[21] = mk(1'b0, 2'd0, 1'b0, 1'b0, 16'h0,    9'd1, 3'd0, 1'b0, 1'b0);
      vt[22] = mk(1'b0, 2'd0, 1'b0, 1'b1, 16'hFFFF, 9'd1, 3'd0, 1'b0, 1'b0);
      vt[23] = mk(1'b0, 2'd0, 1'b0, 1'b1, 16'hFFFF, 9'd1, 3'd0, 1'b0, 1'b0);
      vt[24] = mk(1'b0, 2'd0, 1'b1, 1'b1, 16'hFFFF, 9'd1, 3'd0, 1'b0, 1'b0);
      vt[25] = mk(1'b0, 2'd0, 1'b0, 1'b0, 16'h0,    9'd0, 3'd0, 1'b1, 1'b0);

      // Reset state
      do_reset();
      @(negedge CLK);
      chk("rst_wr_ready", WR_READY, 1);
      chk("rst_rd_valid", RD_VALID, 0);
      chk("rst_word_count", WORD_COUNT, 0);
      chk("rst_partial", PARTIAL, 0);
      chk("rst_empty", EMPTY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_almost_full", ALMOST_FULL, 0);
      chk("rst_enb", RAM_ENB, 0);
      chk("rst_web_rstb", {RAM_WEB, RAM_RSTB}, 0);
      @(posedge CLK); #1;

      // Table-driven vectors
      for (int i = 0; i < 26; i++) begin
         WR_VALID = vt[i].wv; WR_DATA = vt[i].wd; RD_READY = vt[i].rr;
         @(negedge CLK);
         chk($sformatf("vec%0d_wr_ready", i), WR_READY, 1);
         chk($sformatf("vec%0d_wea", i), {RAM_ENA, RAM_WEA}, {vt[i].wv, vt[i].wv});
         chk($sformatf("vec%0d_rd_valid", i), RD_VALID, vt[i].e_rv);
         if (vt[i].e_rv) chk($sformatf("vec%0d_rd_data", i), RD_DATA, vt[i].e_data);
         chk($sformatf("vec%0d_word_count", i), WORD_COUNT, vt[i].e_wc);
         chk($sformatf("vec%0d_partial", i), PARTIAL, vt[i].e_part);
         chk($sformatf("vec%0d_empty", i), EMPTY, vt[i].e_empty);
         chk($sformatf("vec%0d_enb", i), RAM_ENB, vt[i].e_enb);
         @(posedge CLK); #1;
      end

      // Fill to FULL, ALMOST_FULL threshold, blocked 2049th offer
      do_reset();
      for (int k = 0; k < 8; k++) begin
         w0[2*k +: 2] = sym(k);
         w1[2*k +: 2] = sym(8 + k);
      end
      for (int i = 0; i < 2048; i++) begin
         WR_VALID = 1'b1; WR_DATA = sym(i); RD_READY = 1'b0;
         @(negedge CLK);
         chk("fill_wea", RAM_WEA, 1);
         if (i == 1983) chk("af_below_248", ALMOST_FULL, 0);
         if (i == 1984) chk("af_at_248", ALMOST_FULL, 1);
         if (i == 2047) chk("full_before_last", FULL, 0);
         @(posedge CLK); #1;
      end
      WR_DATA = 2'd2;
      @(negedge CLK);
      chk("full_flag", FULL, 1);
      chk("full_wr_ready", WR_READY, 0);
      chk("full_word_count", WORD_COUNT, 256);
      chk("full_af", ALMOST_FULL, 1);
      chk("full_2049_wea", RAM_WEA, 0);
      chk("full_rd_valid", RD_VALID, 1);
      chk("full_word0", RD_DATA, w0);
      @(posedge CLK); #1;

      // Pop from FULL with WR_VALID held: push stays blocked that cycle
      RD_READY = 1'b1; WR_DATA = 2'd1;
      @(negedge CLK);
      chk("pop_full_wr_ready", WR_READY, 0);
      chk("pop_full_wea", RAM_WEA, 0);
      @(posedge CLK); #1;
      RD_READY = 1'b0;
      for (int k = 0; k < 8; k++) begin
         WR_DATA = 2'(k);
         @(negedge CLK);
         chk($sformatf("wrap%0d_wr_ready", k), WR_READY, 1);
         chk($sformatf("wrap%0d_addra", k), RAM_ADDRA, k);
         chk($sformatf("wrap%0d_wea", k), RAM_WEA, 1);
         @(posedge CLK); #1;
      end
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("refull_flag", FULL, 1);
      chk("refull_word_count", WORD_COUNT, 256);
      chk("refull_rd_valid", RD_VALID, 1);
      chk("refull_word1", RD_DATA, w1);
      @(posedge CLK); #1;

      // Reset after 13 symbols, then a fresh word from address 0
      do_reset();
      for (int i = 0; i < 13; i++) begin
         WR_VALID = 1'b1; WR_DATA = sym(i + 5);
         @(posedge CLK); #1;
      end
      RST = 1'b1; WR_VALID = 1'b1; RD_READY = 1'b1;
      @(negedge CLK);
      chk("midrst_wea", RAM_WEA, 0);
      chk("midrst_enb", RAM_ENB, 0);
      @(posedge CLK); #1;
      RST = 1'b0; WR_VALID = 1'b0; RD_READY = 1'b0;
      @(negedge CLK);
      chk("midrst_word_count", WORD_COUNT, 0);
      chk("midrst_partial", PARTIAL, 0);
      chk("midrst_rd_valid", RD_VALID, 0);
      chk("midrst_empty", EMPTY, 1);
      chk("midrst_wr_ready", WR_READY, 1);
      @(posedge CLK); #1;
      for (int k = 0; k < 8; k++) begin
         WR_VALID = 1'b1; WR_DATA = pat[k];
         @(posedge CLK); #1;
      end
      WR_VALID = 1'b0; RD_READY = 1'b1;
      seen_enb = 1'b0; seen_rv = 1'b0; addrb_seen = 8'hFF; expw = 16'h0;
      for (int c = 0; c < 8 && !seen_rv; c++) begin
         @(negedge CLK);
         if (RAM_ENB && !seen_enb) begin seen_enb = 1'b1; addrb_seen = RAM_ADDRB; end
         if (RD_VALID) begin seen_rv = 1'b1; expw = RD_DATA; end
         @(posedge CLK); #1;
      end
      chk("midrst_fetch_seen", seen_enb, 1);
      chk("midrst_addrb", addrb_seen, 0);
      chk("midrst_rv_seen", seen_rv, 1);
      chk("midrst_word", expw, 16'h87D2);
      RD_READY = 1'b0;
      @(posedge CLK); #1;

      // Random stream against a symbol-queue reference
      do_reset();
      symq.delete();
      pushed = 0; popped = 0; cycles = 0; prev_hold = 1'b0; prev_data = 16'h0;
      while ((pushed < 8192 || popped < 1024) && cycles < 60000) begin
         WR_VALID = (pushed < 8192) && ($urandom_range(0, 3) != 0);
         WR_DATA  = 2'($urandom_range(0, 3));
         RD_READY = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (cycles % 16 == 0) begin
            chk("rnd_word_count", WORD_COUNT, symq.size() / 8);
            chk("rnd_partial", PARTIAL, symq.size() % 8);
         end
         if (prev_hold) begin
            chk("rnd_hold_valid", RD_VALID, 1);
            chk("rnd_hold_data", RD_DATA, prev_data);
         end
         if (RD_VALID && RD_READY) begin
            if (symq.size() < 8) begin
               chk("rnd_pop_underflow", symq.size(), 8);
            end else begin
               for (int k = 0; k < 8; k++) expw[2*k +: 2] = symq.pop_front();
               chk($sformatf("rnd_word%0d", popped), RD_DATA, expw);
            end
            popped++;
         end
         if (WR_VALID && WR_READY) begin
            symq.push_back(WR_DATA);
            pushed++;
         end
         prev_hold = RD_VALID && !RD_READY;
         prev_data = RD_DATA;
         @(posedge CLK); #1;
         cycles++;
      end
      if (cycles >= 60000) chk("rnd_timeout_popped", popped, 1024);
      chk("rnd_final_empty", EMPTY, 1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
